alu_seq: RTL and testbench

Parametrised, registered, multi-cycle successor to the CPU's combinational ALU. It adds a start/busy/done handshake, a held Program Status Register, iterative unsigned multiply (double-width product) and unsigned divide (quotient plus remainder). It sits in the CPU execute stage: the controller issues one operation, stalls on `busy`, and takes results and flags on `done`.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq issue/result bundle.
// The CPU controller is master; the ALU is slave.
interface alu_seq_if #(
    parameter int WIDTH     = 16,
    parameter int ALUOPBITS = 4,
    parameter int REGBITS   = 5
);
    logic                 start;
    logic [ALUOPBITS-1:0] aluop;
    logic [WIDTH-1:0]     arg1;
    logic [WIDTH-1:0]     arg2;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic [WIDTH-1:0]     result_hi;
    logic [REGBITS-1:0]   PSRwrite;

    modport master (
        output start, aluop, arg1, arg2,
        input  busy, done, result, result_hi, PSRwrite
    );

    modport slave (
        input  start, aluop, arg1, arg2,
        output busy, done, result, result_hi, PSRwrite
    );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with start/busy/done handshake.
// Single-cycle logic ops; iterative MULU (shift-add) and DIVU (restoring).
module alu_seq #(
    parameter int WIDTH     = 16,
    parameter int ALUOPBITS = 4,
    parameter int REGBITS   = 5
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam logic [ALUOPBITS-1:0] OP_ADD  = ALUOPBITS'(0);
    localparam logic [ALUOPBITS-1:0] OP_SUB  = ALUOPBITS'(1);
    localparam logic [ALUOPBITS-1:0] OP_OR   = ALUOPBITS'(2);
    localparam logic [ALUOPBITS-1:0] OP_AND  = ALUOPBITS'(3);
    localparam logic [ALUOPBITS-1:0] OP_XOR  = ALUOPBITS'(4);
    localparam logic [ALUOPBITS-1:0] OP_NOT  = ALUOPBITS'(5);
    localparam logic [ALUOPBITS-1:0] OP_MULU = ALUOPBITS'(6);
    localparam logic [ALUOPBITS-1:0] OP_CMP  = ALUOPBITS'(7);
    localparam logic [ALUOPBITS-1:0] OP_DIVU = ALUOPBITS'(8);

    logic [0:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [REGBITS-1:0] psr_q, psr_d;

    logic [WIDTH:0]     add_x, sub_x;
    logic [WIDTH-1:0]   a, b, sc_res;
    logic [REGBITS-1:0] sc_psr;
    logic               sc_ok, fc, fl, ff, fz, fn;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH:0]     div_top;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ge;

    assign a = bus.arg1;
    assign b = bus.arg2;

    // Single-cycle result and flags straight from the bus operands.
    always_comb begin
        add_x  = {1'b0, a} + {1'b0, b};
        sub_x  = {1'b0, a} - {1'b0, b};
        sc_res = '0;
        sc_ok  = 1'b1;
        fc = 1'b0; fl = 1'b0; ff = 1'b0; fz = 1'b0; fn = 1'b0;
        case (bus.aluop)
            OP_ADD: begin
                sc_res = add_x[WIDTH-1:0];
                fc = add_x[WIDTH];
                ff = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_x[WIDTH-1:0];
                fc = sub_x[WIDTH];
                ff = (a[WIDTH-1] != b[WIDTH-1]) &&
                     (sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  sc_res = a | b;
            OP_AND: sc_res = a & b;
            OP_XOR: sc_res = a ^ b;
            OP_NOT: sc_res = ~a;
            OP_CMP: begin
                sc_res = sub_x[WIDTH-1:0];
                fl = sub_x[WIDTH];
            end
            default: sc_ok = 1'b0;
        endcase
        fz = (sc_res == '0);
        fn = (bus.aluop == OP_CMP) ? ($signed(a) < $signed(b))
                                   : sc_res[WIDTH-1];
        sc_psr = REGBITS'({fc, fl, ff, fz, fn});
    end

    // One multiply or divide step from the current accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (opd_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_top  = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_top >= {1'b0, b_q});
        div_rem  = div_top[WIDTH-1:0] - b_q;
        div_next = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                          : {acc_q[2*WIDTH-2:0], 1'b0};
    end

    // FSM: accept/compute in IDLE, iterate and finalise in EXEC.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        b_d     = b_q;
        div_d   = div_q;
        done_d  = 1'b0;
        res_d   = res_q;
        hi_d    = hi_q;
        psr_d   = psr_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.aluop == OP_MULU || bus.aluop == OP_DIVU) begin
                        state_d = S_EXEC;
                        cnt_d   = CW'(WIDTH);
                        opd_d   = a;
                        b_d     = b;
                        div_d   = (bus.aluop == OP_DIVU);
                        acc_d   = (bus.aluop == OP_DIVU) ?
                                  {{WIDTH{1'b0}}, a} : '0;
                    end else begin
                        done_d = 1'b1;
                        res_d  = sc_res;
                        hi_d   = '0;
                        if (sc_ok) psr_d = sc_psr;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    acc_d = div_q ? div_next : mul_next;
                    opd_d = div_q ? opd_q : (opd_q >> 1);
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    res_d   = acc_q[WIDTH-1:0];
                    hi_d    = acc_q[2*WIDTH-1:WIDTH];
                    if (div_q) begin
                        if (b_q == '0) begin
                            res_d = '1;
                            hi_d  = opd_q;
                            psr_d = REGBITS'(5'b00100);
                        end else begin
                            psr_d = REGBITS'({3'b000,
                                    acc_q[WIDTH-1:0] == '0, 1'b0});
                        end
                    end else begin
                        psr_d = REGBITS'({acc_q[2*WIDTH-1:WIDTH] != '0,
                                2'b00, acc_q == '0, 1'b0});
                    end
                end
            end
        endcase
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            psr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            b_q     <= b_d;
            div_q   <= div_d;
            done_q  <= done_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            psr_q   <= psr_d;
        end
    end

    assign bus.busy      = (state_q == S_EXEC);
    assign bus.done      = done_q;
    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.PSRwrite  = psr_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16).
// Each task drives one scenario and checks against hand-computed values.
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vecs = 0;
    int errs = 0;

    alu_seq_if #(.WIDTH(16), .ALUOPBITS(4), .REGBITS(5)) bus ();

    alu_seq #(.WIDTH(16), .ALUOPBITS(4), .REGBITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present one request and return 1 time unit after the accepting edge.
    task automatic issue(input logic [3:0] op,
                         input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluop = op;
        bus.arg1  = x;
        bus.arg2  = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0 ||
            bus.result_hi !== 16'h0 || bus.PSRwrite !== 5'b0) begin
            errs++;
            $display("FAIL reset: busy=%b done=%b res=%h hi=%h psr=%b want all 0",
                     bus.busy, bus.done, bus.result, bus.result_hi, bus.PSRwrite);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add;
        issue(4'd0, 16'h7FFF, 16'h0001);
        vecs++;
        if (bus.done !== 1'b1 || bus.result !== 16'h8000 ||
            bus.PSRwrite !== 5'b00101) begin
            errs++;
            $display("FAIL add: done=%b res=%h psr=%b want 1 8000 00101",
                     bus.done, bus.result, bus.PSRwrite);
        end
        @(posedge clk); #1;
        vecs++;
        if (bus.done !== 1'b0 || bus.result !== 16'h8000) begin
            errs++;
            $display("FAIL add_hold: done=%b res=%h want 0 8000",
                     bus.done, bus.result);
        end
    endtask

    task automatic test_sub_cmp;
        issue(4'd1, 16'h0000, 16'h0001);
        vecs++;
        if (bus.done !== 1'b1 || bus.result !== 16'hFFFF ||
            bus.PSRwrite !== 5'b10001) begin
            errs++;
            $display("FAIL sub: done=%b res=%h psr=%b want 1 ffff 10001",
                     bus.done, bus.result, bus.PSRwrite);
        end
        issue(4'd7, 16'h0003, 16'hFFFF);
        vecs++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0004 ||
            bus.PSRwrite !== 5'b01000) begin
            errs++;
            $display("FAIL cmp: done=%b res=%h psr=%b want 1 0004 01000",
                     bus.done, bus.result, bus.PSRwrite);
        end
    endtask

    task automatic test_mulu;
        int lat = 0;
        int busy_n = 0;
        issue(4'd6, 16'h1234, 16'h0100);
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            if (lat == 5) begin
                bus.start = 1'b1;
                bus.aluop = 4'd0;
                bus.arg1  = 16'h0001;
                bus.arg2  = 16'h0001;
            end
            if (lat == 6) bus.start = 1'b0;
            vecs++;
            if (bus.result !== 16'h0004) begin
                errs++;
                $display("FAIL mulu_hold: lat=%0d res=%h want 0004",
                         lat, bus.result);
            end
            @(posedge clk); #1;
            lat++;
        end
        vecs++;
        if (lat != 17 || busy_n != 17 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL mulu_lat: lat=%0d busy_cyc=%0d busy=%b want 17 17 0",
                     lat, busy_n, bus.busy);
        end
        vecs++;
        if (bus.result !== 16'h3400 || bus.result_hi !== 16'h0012 ||
            bus.PSRwrite !== 5'b10000) begin
            errs++;
            $display("FAIL mulu: res=%h hi=%h psr=%b want 3400 0012 10000",
                     bus.result, bus.result_hi, bus.PSRwrite);
        end
        @(posedge clk); #1;
        vecs++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h3400) begin
            errs++;
            $display("FAIL mulu_noqueue: done=%b busy=%b res=%h want 0 0 3400",
                     bus.done, bus.busy, bus.result);
        end
    endtask

    task automatic test_divu;
        logic [15:0] xs [2] = '{16'd100, 16'h1234};
        logic [15:0] ys [2] = '{16'd7, 16'h0000};
        logic [15:0] qs [2] = '{16'h000E, 16'hFFFF};
        logic [15:0] rs [2] = '{16'h0002, 16'h1234};
        logic [4:0]  ps [2] = '{5'b00000, 5'b00100};
        for (int i = 0; i < 2; i++) begin
            int lat = 0;
            issue(4'd8, xs[i], ys[i]);
            while (bus.done !== 1'b1 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            vecs++;
            if (lat != 17 || bus.result !== qs[i] || bus.result_hi !== rs[i] ||
                bus.PSRwrite !== ps[i]) begin
                errs++;
                $display("FAIL divu%0d: lat=%0d q=%h r=%h psr=%b want 17 %h %h %b",
                         i, lat, bus.result, bus.result_hi, bus.PSRwrite,
                         qs[i], rs[i], ps[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        issue(4'd6, 16'h00FF, 16'h00FF);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0 ||
            bus.result_hi !== 16'h0 || bus.PSRwrite !== 5'b0) begin
            errs++;
            $display("FAIL reset_mid: busy=%b done=%b res=%h hi=%h psr=%b want 0",
                     bus.busy, bus.done, bus.result, bus.result_hi, bus.PSRwrite);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        vecs++;
        if (seen != 0) begin
            errs++;
            $display("FAIL reset_nodone: done pulses=%0d want 0", seen);
        end
        issue(4'd0, 16'd2, 16'd3);
        vecs++;
        if (bus.done !== 1'b1 || bus.result !== 16'd5 || bus.result_hi !== 16'h0 ||
            bus.PSRwrite !== 5'b0) begin
            errs++;
            $display("FAIL post_reset_add: done=%b res=%h hi=%h psr=%b want 1 0005 0000 0",
                     bus.done, bus.result, bus.result_hi, bus.PSRwrite);
        end
    endtask

    task automatic test_illegal;
        issue(4'd0, 16'h8000, 16'h8000);
        vecs++;
        if (bus.result !== 16'h0000 || bus.PSRwrite !== 5'b10110) begin
            errs++;
            $display("FAIL add_wrap: res=%h psr=%b want 0000 10110",
                     bus.result, bus.PSRwrite);
        end
        issue(4'd6, 16'h0003, 16'h0005);
        repeat (17) @(posedge clk);
        #1;
        issue(4'd12, 16'h1111, 16'h2222);
        vecs++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0 || bus.result_hi !== 16'h0 ||
            bus.PSRwrite !== 5'b00000) begin
            errs++;
            $display("FAIL illegal_after_mul: done=%b res=%h hi=%h psr=%b want 1 0 0 00000",
                     bus.done, bus.result, bus.result_hi, bus.PSRwrite);
        end
        issue(4'd0, 16'h8000, 16'h8000);
        issue(4'd12, 16'h1111, 16'h2222);
        vecs++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0 || bus.result_hi !== 16'h0 ||
            bus.PSRwrite !== 5'b10110) begin
            errs++;
            $display("FAIL illegal: done=%b res=%h hi=%h psr=%b want 1 0 0 10110",
                     bus.done, bus.result, bus.result_hi, bus.PSRwrite);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluop = 4'd4;
        bus.arg1  = 16'hF0F0;
        bus.arg2  = 16'h0FF0;
        @(posedge clk); #1;
        vecs++;
        if (bus.done !== 1'b1 || bus.result !== 16'hFF00 ||
            bus.PSRwrite !== 5'b00001) begin
            errs++;
            $display("FAIL b2b_first: done=%b res=%h psr=%b want 1 ff00 00001",
                     bus.done, bus.result, bus.PSRwrite);
        end
        bus.arg1 = 16'h00FF;
        bus.arg2 = 16'h00FF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        vecs++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0000 ||
            bus.PSRwrite !== 5'b00010) begin
            errs++;
            $display("FAIL b2b_second: done=%b res=%h psr=%b want 1 0000 00010",
                     bus.done, bus.result, bus.PSRwrite);
        end
        issue(4'd5, 16'h00FF, 16'h0000);
        vecs++;
        if (bus.done !== 1'b1 || bus.result !== 16'hFF00 ||
            bus.PSRwrite !== 5'b00001) begin
            errs++;
            $display("FAIL not: done=%b res=%h psr=%b want 1 ff00 00001",
                     bus.done, bus.result, bus.PSRwrite);
        end
        @(posedge clk); #1;
        vecs++;
        if (bus.done !== 1'b0) begin
            errs++;
            $display("FAIL b2b_end: done=%b want 0", bus.done);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.aluop = 4'd0;
        bus.arg1  = 16'h0;
        bus.arg2  = 16'h0;
        test_reset();
        test_add();
        test_sub_cmp();
        test_mulu();
        test_divu();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
